// File: rtl/data_mem_responder.sv
// Data-side memory responder for the pipelined core: word RAM with byte-lane writes,
// a wait-state FSM that stalls the M stage, and per-size alignment rejection.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_sel,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_addr_err
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("data_mem_responder: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state, state_next;
    logic [3:0]          cnt, cnt_next;
    logic                misaligned;
    logic                accept;
    logic                enter_done;

    logic                cap_wen;
    logic [ADDR_W-1:0]   cap_idx;
    logic [3:0]          cap_sel;
    logic [31:0]         cap_wdata;

    logic                acc_wen;
    logic [ADDR_W-1:0]   acc_idx;
    logic [3:0]          acc_sel;
    logic [31:0]         acc_wdata;

    logic [31:0]         ram [2**ADDR_W];

    // Upper address bits alias onto the array and are intentionally dropped.
    logic                unused_addr;
    assign unused_addr = &{1'b0, mem_addr[31:ADDR_W+2]};

    always_comb begin
        misaligned = 1'b0;
        case (mem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_addr[0];
            2'b10:   misaligned = |mem_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Gating with rst keeps the comb outputs quiet and blocks any write while reset is held.
    assign accept       = rst && (state == IDLE) && mem_en && !misaligned;
    assign mem_stall    = accept || (state == BUSY);
    assign mem_addr_err = rst && (state == IDLE) && mem_en && misaligned;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next = BUSY;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_done = (state_next == DONE);

    // With zero wait states DONE is entered straight from IDLE, before the capture lands.
    always_comb begin
        if (state == IDLE) begin
            acc_wen   = mem_wen;
            acc_idx   = mem_addr[ADDR_W+1:2];
            acc_sel   = mem_sel;
            acc_wdata = mem_wdata;
        end else begin
            acc_wen   = cap_wen;
            acc_idx   = cap_idx;
            acc_sel   = cap_sel;
            acc_wdata = cap_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_rdata <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (enter_done && !acc_wen) begin
                mem_rdata <= ram[acc_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_wen   <= mem_wen;
            cap_idx   <= mem_addr[ADDR_W+1:2];
            cap_sel   <= mem_sel;
            cap_wdata <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_done && acc_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    ram[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with one wait state, one with none, sharing the request bus.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, wen;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [1:0]  size;
    logic [31:0] rdata_a, rdata_b;
    logic        stall_a, stall_b, err_a, err_b;
    logic [31:0] last_rd;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .mem_en(en), .mem_wen(wen), .mem_addr(addr),
        .mem_sel(sel), .mem_size(size), .mem_wdata(wdata),
        .mem_rdata(rdata_a), .mem_stall(stall_a), .mem_addr_err(err_a)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .mem_en(en), .mem_wen(wen), .mem_addr(addr),
        .mem_sel(sel), .mem_size(size), .mem_wdata(wdata),
        .mem_rdata(rdata_b), .mem_stall(stall_b), .mem_addr_err(err_b)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic stall_of(input logic b);
        return b ? stall_b : stall_a;
    endfunction

    function automatic logic [31:0] rdata_of(input logic b);
        return b ? rdata_b : rdata_a;
    endfunction

    // Issue one request; returns in its DONE cycle with the request still driven.
    task automatic access(input logic b, input logic w, input logic [31:0] a,
                          input logic [1:0] sz, input logic [3:0] s, input logic [31:0] d,
                          input int exp_n, input logic [31:0] exp_rd,
                          input logic b2b, input string tag);
        int n;
        en = 1'b1; wen = w; addr = a; size = sz; sel = s; wdata = d;
        if (b2b) @(posedge clk);
        #1;
        n = 0;
        while (stall_of(b) && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk(32'(n), 32'(exp_n), {tag, "_stall_cycles"});
        if (!w) begin
            chk(rdata_of(b), exp_rd, {tag, "_rdata"});
            if (!b) last_rd = exp_rd;
        end else if (!b) begin
            chk(rdata_of(b), last_rd, {tag, "_rdata_held"});
        end
    endtask

    task automatic idle();
        en = 1'b0; wen = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; wen = 1'b0; addr = 32'h0; size = 2'b10; sel = 4'h0; wdata = 32'h0;
        last_rd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk(rdata_a, 32'h0, "reset_rdata");
        chk(32'(stall_a), 32'h0, "reset_stall");
        chk(32'(err_a), 32'h0, "reset_err");
        rst = 1'b1;
        @(posedge clk); #1;

        // Word write then read-back with one wait state
        access(1'b0, 1'b1, 32'h10, 2'b10, 4'hF, 32'hDEADBEEF, 2, 32'h0, 1'b0, "t1_wr");
        idle();
        access(1'b0, 1'b0, 32'h10, 2'b10, 4'h0, 32'h0, 2, 32'hDEADBEEF, 1'b0, "t1_rd");
        idle();

        // Byte and half-word lane merges
        access(1'b0, 1'b1, 32'h10, 2'b10, 4'hF, 32'h11223344, 2, 32'h0, 1'b0, "t2_wr");
        idle();
        access(1'b0, 1'b1, 32'h13, 2'b00, 4'h8, 32'hAA000000, 2, 32'h0, 1'b0, "t2_wrb");
        idle();
        access(1'b0, 1'b0, 32'h10, 2'b10, 4'h0, 32'h0, 2, 32'hAA223344, 1'b0, "t2_rd");
        idle();
        access(1'b0, 1'b1, 32'h12, 2'b01, 4'hC, 32'hBEEF0000, 2, 32'h0, 1'b0, "t2_wrh");
        idle();
        access(1'b0, 1'b0, 32'h10, 2'b10, 4'h0, 32'h0, 2, 32'hBEEF3344, 1'b0, "t2_rdh");
        idle();

        // Misaligned and reserved-size requests are rejected without side effects
        en = 1'b1; wen = 1'b0; addr = 32'h11; size = 2'b01; sel = 4'h0; #1;
        chk(32'(err_a), 32'h1, "t3_half_err");
        chk(32'(stall_a), 32'h0, "t3_half_stall");
        chk(rdata_a, 32'hBEEF3344, "t3_half_rdata");
        @(posedge clk); #1;
        chk(32'(err_a), 32'h1, "t3_half_err_hold");
        chk(32'(stall_a), 32'h0, "t3_half_stall_hold");
        addr = 32'h0; size = 2'b11; #1;
        chk(32'(err_a), 32'h1, "t3_rsvd_err");
        chk(32'(stall_a), 32'h0, "t3_rsvd_stall");
        wen = 1'b1; addr = 32'h12; size = 2'b10; sel = 4'hF; wdata = 32'h0; #1;
        chk(32'(err_a), 32'h1, "t3_word_err");
        chk(32'(stall_a), 32'h0, "t3_word_stall");
        @(posedge clk); #1;
        idle();
        chk(32'(err_a), 32'h0, "t3_err_clear");
        access(1'b0, 1'b0, 32'h10, 2'b10, 4'h0, 32'h0, 2, 32'hBEEF3344, 1'b0, "t3_rd");
        idle();

        // Upper address bits alias onto the same word
        access(1'b0, 1'b1, 32'h1000, 2'b10, 4'hF, 32'h5A5AA5A5, 2, 32'h0, 1'b0, "t6_wr");
        idle();
        access(1'b0, 1'b0, 32'h0, 2'b10, 4'h0, 32'h0, 2, 32'h5A5AA5A5, 1'b0, "t6_rd");
        idle();

        // Reset in the middle of a write drops it
        access(1'b0, 1'b1, 32'h20, 2'b10, 4'hF, 32'h0F0F0F0F, 2, 32'h0, 1'b0, "t5_pre_wr");
        idle();
        access(1'b0, 1'b0, 32'h20, 2'b10, 4'h0, 32'h0, 2, 32'h0F0F0F0F, 1'b0, "t5_pre_rd");
        idle();
        en = 1'b1; wen = 1'b1; addr = 32'h20; size = 2'b10; sel = 4'hF; wdata = 32'h12345678; #1;
        chk(32'(stall_a), 32'h1, "t5_stall_idle");
        @(posedge clk); #1;
        chk(32'(stall_a), 32'h1, "t5_stall_busy");
        rst = 1'b0; #1;
        chk(32'(stall_a), 32'h0, "t5_rst_stall");
        chk(rdata_a, 32'h0, "t5_rst_rdata");
        chk(32'(err_a), 32'h0, "t5_rst_err");
        @(posedge clk); #1;
        en = 1'b0; wen = 1'b0; rst = 1'b1; last_rd = 32'h0;
        @(posedge clk); #1;
        access(1'b0, 1'b0, 32'h20, 2'b10, 4'h0, 32'h0, 2, 32'h0F0F0F0F, 1'b0, "t5_rd");
        idle();

        // Zero wait states: back-to-back read, write, read
        access(1'b1, 1'b1, 32'h40, 2'b10, 4'hF, 32'hCAFEF00D, 1, 32'h0, 1'b0, "t4_init_wr");
        idle();
        access(1'b1, 1'b0, 32'h40, 2'b10, 4'h0, 32'h0, 1, 32'hCAFEF00D, 1'b0, "t4_rd0");
        access(1'b1, 1'b1, 32'h40, 2'b10, 4'hF, 32'h13579BDF, 1, 32'h0, 1'b1, "t4_wr");
        chk(rdata_b, 32'hCAFEF00D, "t4_wr_rdata_held");
        access(1'b1, 1'b0, 32'h40, 2'b10, 4'h0, 32'h0, 1, 32'h13579BDF, 1'b1, "t4_rd1");
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
